alu_arbiter: RTL and testbench

Shares the single 64-bit ALU between two requesters (e.g. the integer pipe and the multi-word sequencer) with round-robin arbitration, a valid/ready request handshake and one-cycle-registered responses. Holds a private carry flag per requester so add/sub-with-carry chains from different requesters can interleave without corrupting each other. Sits between the issue stage and the ALU. It drives the ALU operands and opcode and supplies the carry-in.

---
 rtl/alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter
// ----------------------------------------------------------------------------
// Shares one combinational 64-bit ALU between two requesters (for example the
// integer pipe and the multi-word sequencer).
//
//   * Round-robin arbitration over a valid/ready request handshake.
//   * A single issue register feeds the ALU, so one operation is in flight at
//     a time. The issue register refills on the same edge that it drains,
//     which gives a throughput of one operation per cycle.
//   * Each requester has its own registered response port. The response
//     strobe is one cycle wide; the data, carry and error outputs hold their
//     values between strobes.
//   * Each requester owns a private carry flag. This lets add/sub-with-carry
//     chains from both requesters interleave safely.
//
// Ports
//   clk, reset                      clock and synchronous active-high reset
//   reqN_valid / reqN_ready         request handshake (N = 0, 1)
//   reqN_in_a, reqN_in_b            operands
//   reqN_operand                    ALU opcode
//   rspN_valid                      one-cycle response strobe
//   rspN_out, rspN_carry, rspN_err  result, carry flag after the op, and an
//                                   illegal-opcode flag
//   alu_in_a, alu_in_b, alu_operand operands and opcode driven to the ALU
//   alu_carry_in                    requester carry, used by ADC/SBC only
//   alu_out, alu_carry_out          combinational ALU result and carry
//
// Opcodes
//   0 A     1 B     2 ADD   3 SUB   4 ADC   5 SBC
//   6 NOT A 7 AND   8 OR    9 XOR
//   10..31 are illegal.
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in_a,
    input  logic [DATA_W-1:0] req0_in_b,
    input  logic [OP_W-1:0]   req0_operand,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in_a,
    input  logic [DATA_W-1:0] req1_in_b,
    input  logic [OP_W-1:0]   req1_operand,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_out,
    output logic              rsp0_carry,
    output logic              rsp0_err,

    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_out,
    output logic              rsp1_carry,
    output logic              rsp1_err,

    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [OP_W-1:0]   alu_operand,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry_out
);

    // ------------------------------------------------------------------------
    // Opcode encodings used for classification
    // ------------------------------------------------------------------------
    localparam logic [OP_W-1:0] OP_ADD      = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADC      = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SBC      = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LAST_LEG = OP_W'(9);

    // ------------------------------------------------------------------------
    // Requester inputs gathered into index-addressable form
    // ------------------------------------------------------------------------
    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_a  [2];
    logic [DATA_W-1:0] req_b  [2];
    logic [OP_W-1:0]   req_op [2];

    assign req_valid = {req1_valid, req0_valid};
    assign req_a[0]  = req0_in_a;
    assign req_a[1]  = req1_in_a;
    assign req_b[0]  = req0_in_b;
    assign req_b[1]  = req1_in_b;
    assign req_op[0] = req0_operand;
    assign req_op[1] = req1_operand;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              prio_reg;           // requester that wins a tie
    logic              prio_next;

    logic              issue_valid_reg;
    logic [DATA_W-1:0] issue_a_reg;
    logic [DATA_W-1:0] issue_b_reg;
    logic [OP_W-1:0]   issue_op_reg;
    logic              issue_id_reg;

    logic [1:0]        carry_reg;          // private carry flag per requester

    logic [1:0]        rsp_valid_reg;
    logic [DATA_W-1:0] rsp_out_reg   [2];
    logic [1:0]        rsp_carry_reg;
    logic [1:0]        rsp_err_reg;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // Grants depend only on the valids and the priority pointer; they never
    // depend on ready, so there is no combinational loop through a requester.
    // Reset masks both grants, so a request held during reset is not accepted
    // on the edge where reset is sampled.
    logic [1:0] grant;
    logic       accept;
    logic       grant_id;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (req_valid == 2'b11) begin
                grant[prio_reg] = 1'b1;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign accept   = |grant;
    assign grant_id = grant[1];

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // After each accept, priority passes to the requester that was not served.
    always_comb begin
        prio_next = prio_reg;
        if (accept) begin
            prio_next = ~grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end

    // ------------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------------
    // The register drains and refills on the same edge. issue_valid follows
    // accept directly, so a cycle without an accept leaves the ALU idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_reg <= 1'b0;
            issue_a_reg     <= '0;
            issue_b_reg     <= '0;
            issue_op_reg    <= '0;
            issue_id_reg    <= 1'b0;
        end else begin
            issue_valid_reg <= accept;
            if (accept) begin
                issue_a_reg  <= req_a[grant_id];
                issue_b_reg  <= req_b[grant_id];
                issue_op_reg <= req_op[grant_id];
                issue_id_reg <= grant_id;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Opcode classification for the operation in flight
    // ------------------------------------------------------------------------
    logic op_legal;
    logic op_writes_carry;   // ADD, SUB, ADC and SBC update the carry flag
    logic op_reads_carry;    // only ADC and SBC consume carry-in

    assign op_legal        = (issue_op_reg <= OP_LAST_LEG);
    assign op_writes_carry = (issue_op_reg >= OP_ADD) && (issue_op_reg <= OP_SBC);
    assign op_reads_carry  = (issue_op_reg == OP_ADC) || (issue_op_reg == OP_SBC);

    // ------------------------------------------------------------------------
    // ALU drive
    // ------------------------------------------------------------------------
    // The ALU inputs are forced to zero when idle. This keeps the ALU quiet
    // and gives a deterministic value on the bus.
    always_comb begin
        alu_in_a     = '0;
        alu_in_b     = '0;
        alu_operand  = '0;
        alu_carry_in = 1'b0;
        if (issue_valid_reg) begin
            alu_in_a     = issue_a_reg;
            alu_in_b     = issue_b_reg;
            alu_operand  = issue_op_reg;
            alu_carry_in = op_reads_carry ? carry_reg[issue_id_reg] : 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Per-requester carry flags and response registers
    // ------------------------------------------------------------------------
    // A carry written at the end of one issue cycle is already in carry_reg
    // when the next issue cycle begins. Back-to-back ADC operations from the
    // same requester therefore chain without any forwarding path.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic done;   // this requester's operation completes at this edge

        assign done = issue_valid_reg && (issue_id_reg == 1'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                carry_reg[gi] <= 1'b0;
            end else if (done && op_legal && op_writes_carry) begin
                carry_reg[gi] <= alu_carry_out;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rsp_valid_reg[gi] <= 1'b0;
                rsp_out_reg[gi]   <= '0;
                rsp_carry_reg[gi] <= 1'b0;
                rsp_err_reg[gi]   <= 1'b0;
            end else begin
                rsp_valid_reg[gi] <= done;
                if (done) begin
                    if (!op_legal) begin
                        // Illegal opcode: report an error and leave carry alone.
                        rsp_out_reg[gi]   <= '0;
                        rsp_carry_reg[gi] <= carry_reg[gi];
                        rsp_err_reg[gi]   <= 1'b1;
                    end else begin
                        rsp_out_reg[gi]   <= alu_out;
                        rsp_carry_reg[gi] <= op_writes_carry ? alu_carry_out
                                                             : carry_reg[gi];
                        rsp_err_reg[gi]   <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response ports
    // ------------------------------------------------------------------------
    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp0_out   = rsp_out_reg[0];
    assign rsp0_carry = rsp_carry_reg[0];
    assign rsp0_err   = rsp_err_reg[0];

    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp1_out   = rsp_out_reg[1];
    assign rsp1_carry = rsp_carry_reg[1];
    assign rsp1_err   = rsp_err_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter
// ----------------------------------------------------------------------------
// Directed-vector bench for alu_arbiter with a behavioural 64-bit ALU.
//
// ALU behaviour assumed by the bench:
//   * SUB and SBC report a borrow as the carry.
//   * Non-arithmetic opcodes drive carry-out high. This shows whether the
//     arbiter wrongly samples the ALU carry for those opcodes.
//   * Illegal opcodes return a junk result. This shows whether the arbiter
//     zeroes the result as it should.
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_in_a, req0_in_b, req1_in_a, req1_in_b;
    logic [4:0]  req0_operand, req1_operand;

    logic        rsp0_valid, rsp0_carry, rsp0_err;
    logic        rsp1_valid, rsp1_carry, rsp1_err;
    logic [63:0] rsp0_out, rsp1_out;

    logic [63:0] alu_in_a, alu_in_b, alu_out;
    logic [4:0]  alu_operand;
    logic        alu_carry_in, alu_carry_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(64), .OP_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_in_a     (req0_in_a),
        .req0_in_b     (req0_in_b),
        .req0_operand  (req0_operand),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_in_a     (req1_in_a),
        .req1_in_b     (req1_in_b),
        .req1_operand  (req1_operand),
        .rsp0_valid    (rsp0_valid),
        .rsp0_out      (rsp0_out),
        .rsp0_carry    (rsp0_carry),
        .rsp0_err      (rsp0_err),
        .rsp1_valid    (rsp1_valid),
        .rsp1_out      (rsp1_out),
        .rsp1_carry    (rsp1_carry),
        .rsp1_err      (rsp1_err),
        .alu_in_a      (alu_in_a),
        .alu_in_b      (alu_in_b),
        .alu_operand   (alu_operand),
        .alu_carry_in  (alu_carry_in),
        .alu_out       (alu_out),
        .alu_carry_out (alu_carry_out)
    );

    // ------------------------------------------------------------------------
    // Behavioural ALU
    // ------------------------------------------------------------------------
    logic [64:0] wide;

    always_comb begin
        alu_out       = 64'hDEAD_BEEF_DEAD_BEEF;
        alu_carry_out = 1'b1;
        wide          = '0;
        case (alu_operand)
            5'd0: alu_out = alu_in_a;
            5'd1: alu_out = alu_in_b;
            5'd2: begin
                wide = {1'b0, alu_in_a} + {1'b0, alu_in_b};
                alu_out = wide[63:0];
                alu_carry_out = wide[64];
            end
            5'd3: begin
                wide = {1'b0, alu_in_a} - {1'b0, alu_in_b};
                alu_out = wide[63:0];
                alu_carry_out = wide[64];
            end
            5'd4: begin
                wide = {1'b0, alu_in_a} + {1'b0, alu_in_b} + 65'(alu_carry_in);
                alu_out = wide[63:0];
                alu_carry_out = wide[64];
            end
            5'd5: begin
                wide = {1'b0, alu_in_a} - {1'b0, alu_in_b} - 65'(alu_carry_in);
                alu_out = wide[63:0];
                alu_carry_out = wide[64];
            end
            5'd6: alu_out = ~alu_in_a;
            5'd7: alu_out = alu_in_a & alu_in_b;
            5'd8: alu_out = alu_in_a | alu_in_b;
            5'd9: alu_out = alu_in_a ^ alu_in_b;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; the bench acts 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic v);
        if (id == 0) begin
            req0_valid = v; req0_operand = op; req0_in_a = a; req0_in_b = b;
        end else begin
            req1_valid = v; req1_operand = op; req1_in_a = a; req1_in_b = b;
        end
    endtask

    // Present a lone request, confirm it is granted, and let it be accepted.
    task automatic issue_one(input int id, input logic [4:0] op, input logic [63:0] a,
                             input logic [63:0] b, input string tag);
        drive(id, op, a, b, 1'b1);
        #1;
        check({tag, "_ready"}, (id == 0) ? req0_ready : req1_ready, 1'b1);
        step();
        drive(id, op, a, b, 1'b0);
    endtask

    // Check the response that should be visible in the current cycle.
    task automatic expect_rsp(input int id, input logic [63:0] out, input logic c,
                              input logic e, input string tag);
        logic        v_own, v_oth, c_got, e_got;
        logic [63:0] o_got;
        v_own = (id == 0) ? rsp0_valid : rsp1_valid;
        v_oth = (id == 0) ? rsp1_valid : rsp0_valid;
        o_got = (id == 0) ? rsp0_out   : rsp1_out;
        c_got = (id == 0) ? rsp0_carry : rsp1_carry;
        e_got = (id == 0) ? rsp0_err   : rsp1_err;
        $display("%s: rsp%0d valid=%0d out=%h carry=%0d err=%0d", tag, id, v_own, o_got, c_got, e_got);
        check({tag, "_valid"}, v_own, 1'b1);
        check({tag, "_other_valid"}, v_oth, 1'b0);
        check({tag, "_out"}, o_got, out);
        check({tag, "_carry"}, c_got, c);
        check({tag, "_err"}, e_got, e);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [63:0] vx [4];

    initial begin
        va[0] = 64'h1111; vb[0] = 64'h0101; vx[0] = 64'h1010;
        va[1] = 64'hFF00; vb[1] = 64'h0FF0; vx[1] = 64'hF0F0;
        va[2] = 64'hAAAA; vb[2] = 64'h5555; vx[2] = 64'hFFFF;
        va[3] = 64'h1234; vb[3] = 64'h1234; vx[3] = 64'h0000;

        // Reset with both requesters asking.
        reset = 1'b1;
        drive(0, 5'd2, 64'd5, 64'd7, 1'b1);
        drive(1, 5'd9, 64'hF0, 64'h0F, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_ready0", req0_ready, 1'b0);
            check("rst_ready1", req1_ready, 1'b0);
            check("rst_rsp0_valid", rsp0_valid, 1'b0);
            check("rst_rsp1_valid", rsp1_valid, 1'b0);
        end
        check("rst_rsp0_out", rsp0_out, 64'd0);
        check("rst_rsp0_carry", rsp0_carry, 1'b0);
        $display("reset: ready0=%0d ready1=%0d", req0_ready, req1_ready);

        // Release: req0 wins first, then req1. ADD 5+7 and XOR F0^0F.
        reset = 1'b0;
        #1;
        check("first_ready0", req0_ready, 1'b1);
        check("first_ready1", req1_ready, 1'b0);
        step();
        drive(0, 5'd2, 64'd5, 64'd7, 1'b0);
        #1;
        check("second_ready1", req1_ready, 1'b1);
        check("second_ready0", req0_ready, 1'b0);
        check("issue_alu_op", alu_operand, 5'd2);
        check("issue_alu_a", alu_in_a, 64'd5);
        step();
        drive(1, 5'd9, 64'hF0, 64'h0F, 1'b0);
        expect_rsp(0, 64'd12, 1'b0, 1'b0, "add5_7");
        step();
        expect_rsp(1, 64'hFF, 1'b0, 1'b0, "xor_f0");
        step();
        check("rsp1_strobe_drop", rsp1_valid, 1'b0);
        check("rsp1_hold", rsp1_out, 64'hFF);

        // Alternating grants with both requesters busy.
        drive(0, 5'd9, va[0], vb[0], 1'b1);
        drive(1, 5'd9, va[1], vb[1], 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("alt_ready0", req0_ready, (i % 2) == 0);
            check("alt_ready1", req1_ready, (i % 2) == 1);
            step();
            if (i == 0)      drive(0, 5'd9, va[2], vb[2], 1'b1);
            else if (i == 1) drive(1, 5'd9, va[3], vb[3], 1'b1);
            else if (i == 2) drive(0, 5'd9, va[2], vb[2], 1'b0);
            else             drive(1, 5'd9, va[3], vb[3], 1'b0);
            if (i > 0) expect_rsp((i - 1) % 2, vx[i-1], 1'b0, 1'b0, "alt");
            #1;
        end
        step();
        expect_rsp(1, vx[3], 1'b0, 1'b0, "alt_last");

        // Carry isolation between requesters.
        issue_one(0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "c0_add");
        step(); expect_rsp(0, 64'd0, 1'b1, 1'b0, "c0_add");
        issue_one(1, 5'd4, 64'd0, 64'd0, "c1_adc");
        step(); expect_rsp(1, 64'd0, 1'b0, 1'b0, "c1_adc");
        issue_one(0, 5'd4, 64'd0, 64'd0, "c0_adc");
        step(); expect_rsp(0, 64'd1, 1'b0, 1'b0, "c0_adc");

        // Illegal opcode keeps the carry flag.
        issue_one(1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "c1_add");
        step(); expect_rsp(1, 64'd0, 1'b1, 1'b0, "c1_add");
        issue_one(1, 5'd12, 64'd5, 64'd5, "ill12");
        step(); expect_rsp(1, 64'd0, 1'b1, 1'b1, "ill12");
        issue_one(1, 5'd4, 64'd0, 64'd0, "post_ill_adc");
        step(); expect_rsp(1, 64'd1, 1'b0, 1'b0, "post_ill_adc");

        // Back-to-back ADD then ADC from req0 with no idle cycle between them.
        drive(0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        #1;
        check("b2b_ready_a", req0_ready, 1'b1);
        step();
        drive(0, 5'd4, 64'd0, 64'd0, 1'b1);
        #1;
        check("b2b_ready_b", req0_ready, 1'b1);
        step();
        drive(0, 5'd4, 64'd0, 64'd0, 1'b0);
        expect_rsp(0, 64'd0, 1'b1, 1'b0, "b2b_add");
        step();
        expect_rsp(0, 64'd1, 1'b0, 1'b0, "b2b_adc");

        // Reset during an issue cycle: no response, and the carries are cleared.
        issue_one(0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "pre_rst_add");
        step(); expect_rsp(0, 64'd0, 1'b1, 1'b0, "pre_rst_add");
        issue_one(0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "inflight_add");
        reset = 1'b1;
        step();
        check("midrst_rsp0_valid", rsp0_valid, 1'b0);
        check("midrst_rsp0_out", rsp0_out, 64'd0);
        reset = 1'b0;
        step();
        check("postrst_rsp0_valid", rsp0_valid, 1'b0);
        $display("mid-op reset: rsp0_valid=%0d", rsp0_valid);
        issue_one(0, 5'd4, 64'd0, 64'd0, "postrst_adc");
        step(); expect_rsp(0, 64'd0, 1'b0, 1'b0, "postrst_adc");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
